jtpang_objdma: RTL and testbench

Object DMA engine that consumes the dma_go strobe and busrq_n/busak_n handshake from the Pang main CPU block. On a go request it takes the Z80 bus and copies LEN bytes of object attributes from VRAM/attribute memory into the object line-buffer RAM. It then releases the bus.
It sits between the main CPU bus and the object renderer, and paces itself with the CPU clock enable.

---
 rtl/jtpang_objdma_if.sv | 27 ++
 rtl/jtpang_objdma.sv | 158 +++++++++++++++
 tb/tb_jtpang_objdma.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_objdma_if.sv
// Bus-side signals of the Pang object DMA: CPU bus request/acknowledge,
// source read port and object line-buffer write port.
interface jtpang_objdma_if #(
   parameter int AW  = 12,
   parameter int OAW = 9
);
   logic           busrq_n;
   logic           busak_n;
   logic [AW-1:0]  src_addr;
   logic           src_rd;
   logic [7:0]     src_dout;
   logic [OAW-1:0] obj_addr;
   logic [7:0]     obj_din;
   logic           obj_we;

   // DMA engine side
   modport master (
      output busrq_n, src_addr, src_rd, obj_addr, obj_din, obj_we,
      input  busak_n, src_dout
   );

   // CPU / memory side
   modport slave (
      input  busrq_n, src_addr, src_rd, obj_addr, obj_din, obj_we,
      output busak_n, src_dout
   );
endinterface

// File: rtl/jtpang_objdma.sv
// Pang object DMA: on a dma_go rising edge it takes the Z80 bus, copies LEN
// attribute bytes into the object line buffer, then hands the bus back.
module jtpang_objdma #(
   parameter int            AW       = 12,
   parameter logic [AW-1:0] SRC_BASE = AW'(12'h000),
   parameter int            LEN      = 512,
   parameter int            OAW      = 9
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic            dma_go,
   jtpang_objdma_if.master bus,
   output logic            busy,
   output logic            done
);

   localparam logic [OAW:0] LEN_W  = (OAW+1)'(LEN);
   localparam logic [OAW:0] LAST_W = (OAW+1)'(LEN-1);

   typedef enum logic [1:0] { IDLE, REQ, COPY, RELEASE } state_t;

   state_t         state, state_nx;

   logic           dma_go_p0;
   logic           go_pend;
   logic           go_evt;
   logic           go_seen;

   logic [OAW:0]   rd_cnt;
   logic [OAW:0]   wr_cnt;
   logic           wr_pend;
   logic           rd_more;
   logic           last_wr;

   logic           grant;
   logic           advance;
   logic           release_tick;
   logic           busrq_n;

   logic [AW-1:0]  src_addr;
   logic           src_rd;
   logic [OAW-1:0] obj_addr;
   logic [7:0]     obj_din;
   logic           obj_we;

   // go edge detect runs at full clk rate; a go seen between cen ticks is
   // held in go_pend so the next cen tick still acts on it
   assign go_evt  = dma_go & ~dma_go_p0;
   assign go_seen = go_evt | go_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dma_go_p0 <= 1'b0;
         go_pend   <= 1'b0;
      end else begin
         dma_go_p0 <= dma_go;
         if (cen)         go_pend <= 1'b0;
         else if (go_evt) go_pend <= 1'b1;
      end
   end

   assign rd_more = rd_cnt < LEN_W;
   assign last_wr = wr_pend && (wr_cnt == LAST_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (cen && go_seen)      state_nx = REQ;
         REQ:     if (cen && !bus.busak_n) state_nx = COPY;
         COPY:    if (advance && last_wr)  state_nx = RELEASE;
         RELEASE: if (cen)                 state_nx = IDLE;
         default:                          state_nx = IDLE;
      endcase
   end

   // busrq_n/busy decode straight from state so async reset frees the bus
   always_comb begin
      busrq_n      = 1'b1;
      busy         = 1'b0;
      grant        = 1'b0;
      advance      = 1'b0;
      release_tick = 1'b0;
      case (state)
         REQ: begin
            busrq_n = 1'b0;
            busy    = 1'b1;
            grant   = cen & ~bus.busak_n;
         end
         COPY: begin
            busrq_n = 1'b0;
            busy    = 1'b1;
            advance = cen & ~bus.busak_n;
         end
         RELEASE: begin
            busrq_n      = 1'b0;
            busy         = 1'b1;
            release_tick = cen;
         end
         default: ;
      endcase
   end

   // read of byte k and write of byte k-1 share a tick; a lost grant simply
   // stops advance, so the held src_addr is re-read when the bus returns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_addr <= SRC_BASE;
         src_rd   <= 1'b0;
         obj_addr <= '0;
         obj_din  <= '0;
         obj_we   <= 1'b0;
         done     <= 1'b0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         wr_pend  <= 1'b0;
      end else begin
         obj_we <= 1'b0;
         done   <= 1'b0;
         if (grant) begin
            src_addr <= SRC_BASE;
            src_rd   <= 1'b1;
            rd_cnt   <= (OAW+1)'(1);
            wr_cnt   <= '0;
            wr_pend  <= 1'b1;
         end
         if (advance) begin
            if (wr_pend) begin
               obj_din  <= bus.src_dout;
               obj_addr <= wr_cnt[OAW-1:0];
               obj_we   <= 1'b1;
               wr_cnt   <= wr_cnt + 1'b1;
               if (last_wr) wr_pend <= 1'b0;
            end
            if (rd_more) begin
               src_addr <= SRC_BASE + AW'(rd_cnt);
               rd_cnt   <= rd_cnt + 1'b1;
            end else begin
               src_rd <= 1'b0;
            end
         end
         if (release_tick) done <= 1'b1;
      end
   end

   assign bus.busrq_n  = busrq_n;
   assign bus.src_addr = src_addr;
   assign bus.src_rd   = src_rd;
   assign bus.obj_addr = obj_addr;
   assign bus.obj_din  = obj_din;
   assign bus.obj_we   = obj_we;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: one DUT at SRC_BASE=0 and one at 12'hF00
// for the address wrap, with a delayed bus-acknowledge model and write monitors.
module tb_jtpang_objdma;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic cen    = 1'b0;
   logic dma_go = 1'b0;
   logic go2    = 1'b0;
   logic stall  = 1'b0;
   logic busy, done, wbusy, wdone;
   logic ak1 = 1'b1, ak2 = 1'b1, wak1 = 1'b1, wak2 = 1'b1;
   logic [7:0] mem [0:4095];

   int tests  = 0;
   int failed = 0;

   jtpang_objdma_if #(.AW(12), .OAW(9)) bus ();
   jtpang_objdma_if #(.AW(12), .OAW(9)) wbus ();

   jtpang_objdma u_dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go),
      .bus(bus), .busy(busy), .done(done)
   );

   jtpang_objdma #(.SRC_BASE(12'hF00)) u_wrap (
      .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go2),
      .bus(wbus), .busy(wbusy), .done(wdone)
   );

   always #5 clk = ~clk;

   // source memory answers combinationally; CPU acks two cen ticks after request
   assign bus.src_dout  = mem[bus.src_addr];
   assign wbus.src_dout = mem[wbus.src_addr];
   assign bus.busak_n   = ak2 | stall;
   assign wbus.busak_n  = wak2;

   always @(posedge clk) begin
      if (cen) begin
         ak1  <= bus.busrq_n;
         ak2  <= ak1;
         wak1 <= wbus.busrq_n;
         wak2 <= wak1;
      end
   end

   function automatic logic [7:0] src_val(input int a);
      logic [11:0] aa;
      aa = 12'(a);
      return (aa < 12'h800) ? (aa[7:0] ^ 8'h5A) : (aa[7:0] ^ 8'hC3);
   endfunction

   // monitor state, written only by the negedge block below
   int          cen_per = 1;
   int          phase = 0;
   int          tick = 0;
   int          wr_count = 0, done_count = 0, done_hi = 0;
   int          grant_count = 0, rel_count = 0, brise_count = 0, bfall_count = 0;
   logic [8:0]  cap_addr [0:8191];
   logic [7:0]  cap_din  [0:8191];
   int          we_tick  [0:8191];
   int          grant_tick [0:63];
   int          rel_tick   [0:63];
   int          brise_tick [0:63];
   int          bfall_tick [0:63];
   bit          granted = 1'b0;
   logic        prev_busrq = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;
   int          w_wr = 0, w_rd = 0, w_done = 0;
   logic [7:0]  w_din  [0:2047];
   logic [11:0] w_addr [0:2047];
   logic        w_prev_rd = 1'b0, w_prev_done = 1'b0;
   logic [11:0] w_prev_addr = 12'h000;

   always @(negedge clk) begin
      if (cen) tick++;
      if (bus.obj_we === 1'b1 && wr_count < 8192) begin
         cap_addr[wr_count] = bus.obj_addr;
         cap_din[wr_count]  = bus.obj_din;
         we_tick[wr_count]  = tick;
         wr_count++;
      end
      if (done === 1'b1) done_hi++;
      if (done === 1'b1 && prev_done !== 1'b1) done_count++;
      if (prev_busrq === 1'b0 && bus.busrq_n === 1'b1 && rel_count < 64) begin
         rel_tick[rel_count] = tick; rel_count++;
      end
      if (busy === 1'b1 && prev_busy !== 1'b1 && brise_count < 64) begin
         brise_tick[brise_count] = tick; brise_count++;
      end
      if (busy === 1'b0 && prev_busy === 1'b1 && bfall_count < 64) begin
         bfall_tick[bfall_count] = tick; bfall_count++;
      end
      if (bus.busrq_n === 1'b1) granted = 1'b0;
      prev_busrq = bus.busrq_n;
      prev_busy  = busy;
      prev_done  = done;
      if (wbus.obj_we === 1'b1 && w_wr < 2048) begin
         w_din[w_wr] = wbus.obj_din; w_wr++;
      end
      if (wbus.src_rd === 1'b1 && (w_prev_rd !== 1'b1 || wbus.src_addr !== w_prev_addr)
          && w_rd < 2048) begin
         w_addr[w_rd] = wbus.src_addr; w_rd++;
      end
      w_prev_rd   = wbus.src_rd;
      w_prev_addr = wbus.src_addr;
      if (wdone === 1'b1 && w_prev_done !== 1'b1) w_done++;
      w_prev_done = wdone;
      // cen for the coming posedge, then look ahead for the grant it samples
      phase = (phase + 1 >= cen_per) ? 0 : phase + 1;
      cen   = (phase == 0);
      if (cen && !granted && bus.busrq_n === 1'b0 && bus.busak_n === 1'b0 && grant_count < 64) begin
         granted = 1'b1;
         grant_tick[grant_count] = tick + 1;
         grant_count++;
      end
   end

   task automatic pulse_go();
      @(negedge clk); dma_go = 1'b1;
      @(negedge clk); dma_go = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      int t0;
      t0 = tick;
      while (tick < t0 + n) begin @(negedge clk); #1; end
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_count >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_writes(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (wr_count >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      tests++; if (bus.busrq_n !== 1'b1) begin failed++; $display("FAIL reset_busrq_n: got %b want 1", bus.busrq_n); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (bus.src_rd !== 1'b0) begin failed++; $display("FAIL reset_src_rd: got %b want 0", bus.src_rd); end
      tests++; if (bus.obj_we !== 1'b0) begin failed++; $display("FAIL reset_obj_we: got %b want 0", bus.obj_we); end
      tests++; if (bus.src_addr !== 12'h000) begin failed++; $display("FAIL reset_src_addr: got %h want 000", bus.src_addr); end
      tests++; if (wbus.src_addr !== 12'hF00) begin failed++; $display("FAIL reset_wrap_src_addr: got %h want f00", wbus.src_addr); end
      tests++; if (bus.obj_addr !== 9'h000) begin failed++; $display("FAIL reset_obj_addr: got %h want 000", bus.obj_addr); end
      tests++; if (bus.obj_din !== 8'h00) begin failed++; $display("FAIL reset_obj_din: got %h want 00", bus.obj_din); end
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(4);
   endtask

   task automatic test_basic();
      int base, d0, dh0, r0, bad;
      bit ok;
      cen_per = 1;
      wait_ticks(4);
      base = wr_count; d0 = done_count; dh0 = done_hi; r0 = rel_count;
      pulse_go();
      wait_done(d0 + 1, 3000, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL basic_timeout: done count %0d want %0d", done_count, d0 + 1); end
      tests++; if (wr_count - base !== 512) begin failed++; $display("FAIL basic_count: got %0d writes want 512", wr_count - base); end
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (cap_addr[base+i] !== 9'(i) || cap_din[base+i] !== src_val(i)) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL basic_data: %0d wrong writes want 0", bad); end
      tests++; if (done_hi - dh0 !== 1) begin failed++; $display("FAIL basic_done_width: got %0d clks want 1", done_hi - dh0); end
      tests++; if (rel_tick[r0] - we_tick[base+511] !== 1) begin
         failed++; $display("FAIL basic_release_gap: got %0d cen want 1", rel_tick[r0] - we_tick[base+511]);
      end
   endtask

   task automatic test_latency();
      int base, d0, dh0, r0, g0, br0, bf0;
      bit ok;
      cen_per = 4;
      wait_ticks(4);
      base = wr_count; d0 = done_count; dh0 = done_hi; r0 = rel_count;
      g0 = grant_count; br0 = brise_count; bf0 = bfall_count;
      pulse_go();
      wait_writes(base + 10, 400, ok);
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL lat_busy_mid: got %b want 1", busy); end
      wait_done(d0 + 1, 4000, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL lat_timeout: done count %0d want %0d", done_count, d0 + 1); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL lat_busy_end: got %b want 0", busy); end
      tests++; if (grant_tick[g0] - brise_tick[br0] !== 3) begin
         failed++; $display("FAIL lat_req_to_grant: got %0d cen want 3", grant_tick[g0] - brise_tick[br0]);
      end
      tests++; if (we_tick[base] - grant_tick[g0] !== 1) begin
         failed++; $display("FAIL lat_first_write: got %0d cen want 1", we_tick[base] - grant_tick[g0]);
      end
      tests++; if (we_tick[base+511] - grant_tick[g0] !== 512) begin
         failed++; $display("FAIL lat_last_write: got %0d cen want 512", we_tick[base+511] - grant_tick[g0]);
      end
      tests++; if (rel_tick[r0] - grant_tick[g0] !== 513) begin
         failed++; $display("FAIL lat_copy_release: got %0d cen want 513", rel_tick[r0] - grant_tick[g0]);
      end
      tests++; if (bfall_tick[bf0] !== rel_tick[r0]) begin
         failed++; $display("FAIL lat_busy_fall: got tick %0d want %0d", bfall_tick[bf0], rel_tick[r0]);
      end
      tests++; if (done_hi - dh0 !== 1) begin failed++; $display("FAIL lat_done_width: got %0d clks want 1", done_hi - dh0); end
   endtask

   task automatic test_stall();
      int base, d0, bad;
      bit ok;
      cen_per = 2;
      wait_ticks(4);
      base = wr_count; d0 = done_count;
      pulse_go();
      wait_writes(base + 100, 1000, ok);
      stall = 1'b1;
      wait_ticks(10);
      tests++; if (wr_count - base !== 100) begin failed++; $display("FAIL stall_no_writes: got %0d writes want 100", wr_count - base); end
      tests++; if (bus.obj_addr !== 9'd99) begin failed++; $display("FAIL stall_addr_hold: got %0d want 99", bus.obj_addr); end
      stall = 1'b0;
      wait_done(d0 + 1, 3000, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL stall_timeout: done count %0d want %0d", done_count, d0 + 1); end
      tests++; if (wr_count - base !== 512) begin failed++; $display("FAIL stall_count: got %0d writes want 512", wr_count - base); end
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (cap_addr[base+i] !== 9'(i) || cap_din[base+i] !== src_val(i)) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL stall_data: %0d wrong writes want 0", bad); end
   endtask

   task automatic test_retrigger();
      int base, d0, g0, bad;
      bit ok;
      cen_per = 2;
      wait_ticks(4);
      base = wr_count; d0 = done_count; g0 = grant_count;
      @(negedge clk); dma_go = 1'b1;
      wait_ticks(3);
      dma_go = 1'b0;
      wait_writes(base + 50, 1000, ok);
      pulse_go();
      wait_done(d0 + 1, 3000, ok);
      wait_ticks(20);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL retrig_timeout: done count %0d want %0d", done_count, d0 + 1); end
      tests++; if (grant_count - g0 !== 1) begin failed++; $display("FAIL retrig_single: got %0d transfers want 1", grant_count - g0); end
      tests++; if (wr_count - base !== 512) begin failed++; $display("FAIL retrig_count: got %0d writes want 512", wr_count - base); end
      tests++; if (bus.busrq_n !== 1'b1) begin failed++; $display("FAIL retrig_idle: busrq_n %b want 1", bus.busrq_n); end
      base = wr_count; d0 = done_count;
      pulse_go();
      wait_done(d0 + 1, 3000, ok);
      tests++; if (wr_count - base !== 512) begin failed++; $display("FAIL retrig_second: got %0d writes want 512", wr_count - base); end
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (cap_addr[base+i] !== 9'(i) || cap_din[base+i] !== src_val(i)) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL retrig_data: %0d wrong writes want 0", bad); end
   endtask

   task automatic test_back_to_back();
      int base, d0, g0, guard;
      bit ok;
      cen_per = 1;
      wait_ticks(4);
      d0 = done_count; g0 = grant_count;
      pulse_go();
      guard = 0;
      while (done !== 1'b1 && guard < 3000) begin @(negedge clk); guard++; end
      dma_go = 1'b1;
      @(negedge clk); dma_go = 1'b0;
      base = wr_count;
      wait_done(d0 + 2, 3000, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL b2b_timeout: done count %0d want %0d", done_count, d0 + 2); end
      tests++; if (grant_count - g0 !== 2) begin failed++; $display("FAIL b2b_transfers: got %0d want 2", grant_count - g0); end
      tests++; if (wr_count - base !== 512) begin failed++; $display("FAIL b2b_count: got %0d writes want 512", wr_count - base); end
   endtask

   task automatic test_wrap();
      int wb, rb, d0, bad;
      bit ok;
      cen_per = 1;
      wait_ticks(4);
      wb = w_wr; rb = w_rd; d0 = w_done;
      @(negedge clk); go2 = 1'b1;
      @(negedge clk); go2 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         if (w_done > d0) begin ok = 1'b1; break; end
      end
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL wrap_timeout: wrap done not seen"); end
      tests++; if (w_rd - rb !== 512) begin failed++; $display("FAIL wrap_reads: got %0d addresses want 512", w_rd - rb); end
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (w_addr[rb+i] !== 12'(12'hF00 + i)) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL wrap_addr: %0d wrong addresses want 0", bad); end
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (w_din[wb+i] !== src_val((12'hF00 + i) & 12'hFFF)) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL wrap_data: %0d wrong bytes want 0", bad); end
      tests++; if (wbusy !== 1'b0) begin failed++; $display("FAIL wrap_busy_end: got %b want 0", wbusy); end
   endtask

   task automatic test_async_reset();
      int base, d0, bad;
      bit ok;
      cen_per = 1;
      wait_ticks(4);
      base = wr_count;
      pulse_go();
      wait_writes(base + 200, 1000, ok);
      rst_n = 1'b0;
      #1;
      tests++; if (bus.busrq_n !== 1'b1) begin failed++; $display("FAIL arst_busrq_n: got %b want 1", bus.busrq_n); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL arst_busy: got %b want 0", busy); end
      tests++; if (bus.obj_addr !== 9'd0) begin failed++; $display("FAIL arst_obj_addr: got %0d want 0", bus.obj_addr); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(4);
      tests++; if (bus.busrq_n !== 1'b1) begin failed++; $display("FAIL arst_stays_idle: busrq_n %b want 1", bus.busrq_n); end
      base = wr_count; d0 = done_count;
      pulse_go();
      wait_done(d0 + 1, 3000, ok);
      tests++; if (wr_count - base !== 512) begin failed++; $display("FAIL arst_recopy_count: got %0d writes want 512", wr_count - base); end
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (cap_addr[base+i] !== 9'(i) || cap_din[base+i] !== src_val(i)) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL arst_recopy_data: %0d wrong writes want 0", bad); end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = src_val(a);
      test_reset();
      test_basic();
      test_latency();
      test_stall();
      test_retrigger();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
